// File: rtl/clint_rtc_pkg.sv
// rtl/clint_rtc_pkg.sv - CLINT window defaults, register offsets and byte-merge helper
//
// Purpose: shared constants for clint_rtc and its RTC divider.
// Ports:   none (package).

package clint_rtc_pkg;

   // Platform defaults for the CLINT window and the RTC divider terminal count.
   localparam logic [31:0] CLINT_BASE_ADDR = 32'h0200_0000;
   localparam int          CLK_DIVIDER_RTC = 4;

   // Register offsets inside the window.
   localparam logic [15:0] MSIP_OFF        = 16'h0000;
   localparam logic [15:0] MTIMECMP_OFF    = 16'h4000;
   localparam logic [15:0] MTIMECMP_HI_OFF = MTIMECMP_OFF + 16'h0004;
   localparam logic [15:0] MTIME_OFF       = 16'hBFF8;
   localparam logic [15:0] MTIME_HI_OFF    = MTIME_OFF + 16'h0004;

   // Replace the bytes of old_w selected by strb with the matching bytes of new_w.
   function automatic logic [31:0] merge_wstrb(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_w;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) begin
            res[i*8 +: 8] = new_w[i*8 +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rtc_divider.sv
// rtl/rtc_divider.sv - RTC tick generator, one tick every 2*(RTC_DIV+1) clocks
//
// Purpose: divides the system clock into a single-cycle mtime increment strobe.
// Ports:   clk_i  - system clock
//          rst_ni - asynchronous active-low reset
//          tick_o - one-cycle strobe, high while cnt==RTC_DIV in the odd phase

module rtc_divider #(
   parameter int RTC_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic tick_o
);

   // +2 keeps the counter at least one bit wide even for RTC_DIV==0.
   localparam int            CW   = $clog2(RTC_DIV + 2);
   localparam logic [CW-1:0] TERM = CW'(RTC_DIV);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;
   logic          at_term;

   assign at_term = (cnt_q == TERM);

   always_comb begin
      cnt_d   = at_term ? '0 : cnt_q + CW'(1);
      phase_d = phase_q ^ at_term;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   // The phase bit halves the wrap rate so the tick lands once per two wraps.
   assign tick_o = at_term && phase_q;

endmodule

// File: rtl/clint_rtc.sv
// rtl/clint_rtc.sv - CLINT responder: msip, mtimecmp and RTC-driven mtime
//
// Purpose: memory-mapped CLINT with fixed one-cycle response latency.
// Ports:   clock, reset      - system clock, asynchronous active-low reset
//          mem_valid/instr   - request strobe; fetch flag (treated as read)
//          mem_addr/wdata    - byte address (word aligned), write data
//          mem_wstrb         - byte enables, 0000 = read
//          mem_rdata/ready   - registered response, one cycle after request
//          timer_irpt        - MTIP, registered mtime >= mtimecmp
//          soft_irpt         - MSIP, msip bit 0

module clint_rtc
   import clint_rtc_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = CLINT_BASE_ADDR,
   parameter int          RTC_DIV   = CLK_DIVIDER_RTC
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        timer_irpt,
   output logic        soft_irpt
);

   localparam logic [13:0] MSIP_W        = MSIP_OFF[15:2];
   localparam logic [13:0] MTIMECMP_LO_W = MTIMECMP_OFF[15:2];
   localparam logic [13:0] MTIMECMP_HI_W = MTIMECMP_HI_OFF[15:2];
   localparam logic [13:0] MTIME_LO_W    = MTIME_OFF[15:2];
   localparam logic [13:0] MTIME_HI_W    = MTIME_HI_OFF[15:2];

   logic [63:0] mtime_q, mtime_d, mtime_inc;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic        msip_q, msip_d;
   logic [31:0] rdata_q, rdata_d, rd_sel;
   logic        ready_q;
   logic        timer_q;
   logic        tick;
   logic        wr;
   logic [31:0] offset;
   logic [13:0] word;
   logic        unused_ok;

   rtc_divider #(
      .RTC_DIV (RTC_DIV)
   ) u_rtc_divider (
      .clk_i  (clock),
      .rst_ni (reset),
      .tick_o (tick)
   );

   assign offset = mem_addr - BASE_ADDR;
   assign word   = offset[15:2];
   assign wr     = mem_valid && (mem_wstrb != 4'b0000);

   // Fetches read like loads; the window is decoded on the low 16 offset bits only.
   assign unused_ok = ^{mem_instr, offset[31:16], offset[1:0]};

   // Read mux over the pre-write register values.
   always_comb begin
      rd_sel = '0;
      case (word)
         MSIP_W:        rd_sel = {31'd0, msip_q};
         MTIMECMP_LO_W: rd_sel = mtimecmp_q[31:0];
         MTIMECMP_HI_W: rd_sel = mtimecmp_q[63:32];
         MTIME_LO_W:    rd_sel = mtime_q[31:0];
         MTIME_HI_W:    rd_sel = mtime_q[63:32];
         default:       rd_sel = '0;
      endcase
   end

   // Written bytes override the incremented mtime; the other bytes and word
   // keep the increment, carry included.
   always_comb begin
      mtime_inc  = mtime_q + {63'd0, tick};
      mtime_d    = mtime_inc;
      mtimecmp_d = mtimecmp_q;
      msip_d     = msip_q;
      if (wr) begin
         case (word)
            MSIP_W:        if (mem_wstrb[0]) msip_d = mem_wdata[0];
            MTIMECMP_LO_W: mtimecmp_d[31:0]  = merge_wstrb(mtimecmp_q[31:0],  mem_wdata, mem_wstrb);
            MTIMECMP_HI_W: mtimecmp_d[63:32] = merge_wstrb(mtimecmp_q[63:32], mem_wdata, mem_wstrb);
            MTIME_LO_W:    mtime_d[31:0]     = merge_wstrb(mtime_inc[31:0],   mem_wdata, mem_wstrb);
            MTIME_HI_W:    mtime_d[63:32]    = merge_wstrb(mtime_inc[63:32],  mem_wdata, mem_wstrb);
            default:       ;
         endcase
      end
      rdata_d = mem_valid ? rd_sel : 32'd0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         msip_q     <= 1'b0;
         rdata_q    <= '0;
         ready_q    <= 1'b0;
         timer_q    <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         msip_q     <= msip_d;
         rdata_q    <= rdata_d;
         ready_q    <= mem_valid;
         // Compares the already-committed values, so MTIP trails any change by a cycle.
         timer_q    <= (mtime_q >= mtimecmp_q);
      end
   end

   assign mem_rdata  = rdata_q;
   assign mem_ready  = ready_q;
   assign timer_irpt = timer_q;
   assign soft_irpt  = msip_q;

endmodule

// File: tb/tb_clint_rtc.sv
// tb/tb_clint_rtc.sv - self-checking bench for clint_rtc

module tb_clint_rtc;

   localparam logic [31:0] BASE   = 32'h0200_0000;
   localparam int          PERIOD = 2 * (4 + 1);

   logic        clock = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_valid = 1'b0;
   logic        mem_instr = 1'b0;
   logic [31:0] mem_addr  = '0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_wstrb = '0;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        timer_irpt;
   logic        soft_irpt;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clock = ~clock;

   clint_rtc dut (
      .clock      (clock),
      .reset      (rst_n),
      .mem_valid  (mem_valid),
      .mem_instr  (mem_instr),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .timer_irpt (timer_irpt),
      .soft_irpt  (soft_irpt)
   );

   // Reference model: time counted in clock edges since reset release,
   // mtime advances on every PERIOD-th edge.
   logic [63:0] m_mtime, m_cmp, nt;
   logic        m_msip, m_ready, m_timer;
   logic [31:0] m_rdata, mrd;
   logic [15:0] mo;
   int          m_edge;

   function automatic logic [31:0] put_bytes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
      return r;
   endfunction

   always @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         m_edge = 0; m_mtime = 64'd0; m_cmp = {64{1'b1}}; m_msip = 1'b0;
         m_ready = 1'b0; m_rdata = 32'd0; m_timer = 1'b0;
      end else begin
         m_edge  = m_edge + 1;
         m_timer = (m_mtime >= m_cmp);
         mo = 16'(mem_addr - BASE) & 16'hFFFC;
         case (mo)
            16'h0000: mrd = {31'd0, m_msip};
            16'h4000: mrd = m_cmp[31:0];
            16'h4004: mrd = m_cmp[63:32];
            16'hBFF8: mrd = m_mtime[31:0];
            16'hBFFC: mrd = m_mtime[63:32];
            default:  mrd = 32'd0;
         endcase
         m_ready = mem_valid;
         m_rdata = mem_valid ? mrd : 32'd0;
         nt = m_mtime + ((m_edge % PERIOD == 0) ? 64'd1 : 64'd0);
         if (mem_valid && mem_wstrb != 4'd0) begin
            case (mo)
               16'h0000: if (mem_wstrb[0]) m_msip = mem_wdata[0];
               16'h4000: m_cmp[31:0]  = put_bytes(m_cmp[31:0],  mem_wdata, mem_wstrb);
               16'h4004: m_cmp[63:32] = put_bytes(m_cmp[63:32], mem_wdata, mem_wstrb);
               16'hBFF8: nt[31:0]     = put_bytes(nt[31:0],     mem_wdata, mem_wstrb);
               16'hBFFC: nt[63:32]    = put_bytes(nt[63:32],    mem_wdata, mem_wstrb);
               default: ;
            endcase
         end
         m_mtime = nt;
      end
   end

   // One request issued at a negedge; returns the response seen one cycle later.
   task automatic bus(input logic [15:0] off, input logic [31:0] d, input logic [3:0] s,
                      output logic rdy, output logic [31:0] rd);
      mem_valid = 1'b1; mem_addr = BASE + {16'd0, off}; mem_wdata = d; mem_wstrb = s;
      @(negedge clock);
      mem_valid = 1'b0; mem_wstrb = 4'd0;
      rdy = mem_ready; rd = mem_rdata;
   endtask

   task automatic test_reset();
      logic r; logic [31:0] d;
      rst_n = 1'b0;
      repeat (3) @(negedge clock);
      tests_run++; if (mem_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got %b want 0", mem_ready); end
      tests_run++; if (mem_rdata !== 32'd0) begin tests_failed++; $display("FAIL reset_rdata got %h want 0", mem_rdata); end
      tests_run++; if (timer_irpt !== 1'b0 || soft_irpt !== 1'b0) begin tests_failed++; $display("FAIL reset_irpt got %b%b want 00", timer_irpt, soft_irpt); end
      rst_n = 1'b1;
      repeat (100) @(negedge clock);
      bus(16'hBFF8, 32'd0, 4'd0, r, d);
      tests_run++; if (r !== 1'b1 || d !== 32'h0000_000A) begin tests_failed++; $display("FAIL idle_mtime got rdy=%b %h want 1 0000000a", r, d); end
      tests_run++; if (timer_irpt !== 1'b0 || soft_irpt !== 1'b0) begin tests_failed++; $display("FAIL idle_irpt got %b%b want 00", timer_irpt, soft_irpt); end
      bus(16'h4004, 32'd0, 4'd0, r, d);
      tests_run++; if (d !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL reset_cmp_hi got %h want ffffffff", d); end
   endtask

   task automatic test_timer();
      logic r; logic [31:0] d; int n;
      bus(16'h4000, 32'h0000_0014, 4'hF, r, d);
      bus(16'h4004, 32'h0000_0000, 4'hF, r, d);
      n = 0;
      while (timer_irpt !== 1'b1 && n < 400) begin
         tests_run++; if (timer_irpt !== m_timer) begin tests_failed++; $display("FAIL timer_track got %b want %b", timer_irpt, m_timer); end
         @(negedge clock); n++;
      end
      tests_run++; if (timer_irpt !== 1'b1 || m_edge != 201 || m_mtime != 64'd20) begin
         tests_failed++; $display("FAIL timer_rise got irpt=%b at edge %0d mtime %0d want 1 at 201 mtime 20", timer_irpt, m_edge, m_mtime); end
      bus(16'h4000, 32'hFFFF_FFFF, 4'hF, r, d);
      tests_run++; if (timer_irpt !== 1'b1) begin tests_failed++; $display("FAIL timer_hold got %b want 1", timer_irpt); end
      @(negedge clock);
      tests_run++; if (timer_irpt !== 1'b0) begin tests_failed++; $display("FAIL timer_clear got %b want 0", timer_irpt); end
   endtask

   task automatic test_msip();
      logic r; logic [31:0] d;
      bus(16'h0000, 32'hFFFF_FFFF, 4'hF, r, d);
      tests_run++; if (soft_irpt !== 1'b1 || m_msip !== 1'b1) begin tests_failed++; $display("FAIL msip_set got %b want 1", soft_irpt); end
      bus(16'h0000, 32'd0, 4'd0, r, d);
      tests_run++; if (d !== 32'h0000_0001) begin tests_failed++; $display("FAIL msip_read got %h want 00000001", d); end
      bus(16'h0000, 32'd0, 4'hF, r, d);
      tests_run++; if (soft_irpt !== 1'b0) begin tests_failed++; $display("FAIL msip_clear got %b want 0", soft_irpt); end
   endtask

   task automatic test_carry();
      logic r; logic [31:0] d, exp_lo; logic [63:0] pre; int n;
      n = 0; while (m_edge % PERIOD != 1 && n < 2*PERIOD) begin @(negedge clock); n++; end
      bus(16'hBFF8, 32'hFFFF_FFFF, 4'hF, r, d);
      bus(16'hBFFC, 32'h0000_0000, 4'hF, r, d);
      n = 0; while (m_edge % PERIOD != 0 && n < 2*PERIOD) begin @(negedge clock); n++; end
      bus(16'hBFF8, 32'd0, 4'd0, r, d);
      tests_run++; if (d !== 32'd0) begin tests_failed++; $display("FAIL carry_lo got %h want 0", d); end
      bus(16'hBFFC, 32'd0, 4'd0, r, d);
      tests_run++; if (d !== 32'd1) begin tests_failed++; $display("FAIL carry_hi got %h want 1", d); end
      n = 0; while (m_edge % PERIOD != PERIOD-1 && n < 2*PERIOD) begin @(negedge clock); n++; end
      pre = m_mtime + 64'd1;
      exp_lo = {pre[31:8], 8'hAB};
      bus(16'hBFF8, 32'h0000_00AB, 4'b0001, r, d);
      bus(16'hBFF8, 32'd0, 4'd0, r, d);
      tests_run++; if (d !== exp_lo) begin tests_failed++; $display("FAIL tick_byte_lo got %h want %h", d, exp_lo); end
      bus(16'hBFFC, 32'd0, 4'd0, r, d);
      tests_run++; if (d !== pre[63:32]) begin tests_failed++; $display("FAIL tick_byte_hi got %h want %h", d, pre[63:32]); end
   endtask

   task automatic test_back_to_back();
      logic r; logic [31:0] d, exp1; logic [63:0] cmp0;
      exp1 = m_mtime[31:0]; cmp0 = m_cmp;
      mem_valid = 1'b1; mem_addr = BASE + 32'hBFF8; mem_wstrb = 4'd0;
      @(negedge clock);
      tests_run++; if (mem_ready !== 1'b1 || mem_rdata !== exp1) begin tests_failed++; $display("FAIL b2b_1 got %b %h want 1 %h", mem_ready, mem_rdata, exp1); end
      mem_addr = BASE + 32'h1234;
      @(negedge clock);
      tests_run++; if (mem_ready !== 1'b1 || mem_rdata !== 32'd0) begin tests_failed++; $display("FAIL b2b_2 got %b %h want 1 0", mem_ready, mem_rdata); end
      mem_wdata = $urandom; mem_wstrb = 4'hF;
      @(negedge clock);
      mem_valid = 1'b0; mem_wstrb = 4'd0;
      tests_run++; if (mem_ready !== 1'b1 || mem_rdata !== 32'd0) begin tests_failed++; $display("FAIL b2b_3 got %b %h want 1 0", mem_ready, mem_rdata); end
      @(negedge clock);
      tests_run++; if (mem_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_end got %b want 0", mem_ready); end
      bus(16'h1234, 32'd0, 4'd0, r, d);
      tests_run++; if (d !== 32'd0) begin tests_failed++; $display("FAIL unmapped_read got %h want 0", d); end
      bus(16'h4000, 32'd0, 4'd0, r, d);
      tests_run++; if (d !== cmp0[31:0]) begin tests_failed++; $display("FAIL unmapped_write got %h want %h", d, cmp0[31:0]); end
   endtask

   task automatic test_random();
      logic [15:0] offs [6];
      offs[0] = 16'h0000; offs[1] = 16'h4000; offs[2] = 16'h4004;
      offs[3] = 16'hBFF8; offs[4] = 16'hBFFC; offs[5] = 16'h0000;
      for (int i = 0; i < 300; i++) begin
         mem_valid = ($urandom_range(0, 3) != 0);
         mem_instr = $urandom_range(0, 1);
         mem_addr  = BASE + {16'd0, offs[$urandom_range(0, 5)]};
         if ($urandom_range(0, 7) == 0) mem_addr = BASE + {16'd0, $urandom_range(0, 16383) * 4};
         mem_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
         mem_wdata = $urandom;
         if (mem_addr == BASE + 32'h4000) mem_wdata = m_mtime[31:0] + $urandom_range(0, 40) - 20;
         if (mem_addr == BASE + 32'h4004 || mem_addr == BASE + 32'hBFFC) mem_wdata = 32'd0;
         @(negedge clock);
         tests_run++; if (mem_ready !== m_ready || mem_rdata !== m_rdata) begin
            tests_failed++; $display("FAIL rand_resp cyc %0d got %b %h want %b %h", i, mem_ready, mem_rdata, m_ready, m_rdata); end
         tests_run++; if (timer_irpt !== m_timer || soft_irpt !== m_msip) begin
            tests_failed++; $display("FAIL rand_irpt cyc %0d got %b%b want %b%b", i, timer_irpt, soft_irpt, m_timer, m_msip); end
      end
      mem_valid = 1'b0; mem_wstrb = 4'd0; mem_instr = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic r; logic [31:0] d; int bad;
      bus(16'h0000, 32'd1, 4'hF, r, d);
      bus(16'h4000, 32'd0, 4'hF, r, d);
      bus(16'h4004, 32'd0, 4'hF, r, d);
      mem_valid = 1'b1; mem_addr = BASE + 32'hBFF8; mem_wstrb = 4'd0;
      @(posedge clock); #1;
      mem_valid = 1'b0;
      rst_n = 1'b0; #1;
      tests_run++; if (mem_ready !== 1'b0 || mem_rdata !== 32'd0) begin tests_failed++; $display("FAIL rst_mid_ready got %b %h want 0 0", mem_ready, mem_rdata); end
      tests_run++; if (timer_irpt !== 1'b0 || soft_irpt !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_irpt got %b%b want 00", timer_irpt, soft_irpt); end
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
      bad = 0;
      repeat (5) begin @(negedge clock); if (mem_ready !== 1'b0) bad++; end
      tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL rst_no_resp got %0d ready pulses want 0", bad); end
      bus(16'h4000, 32'd0, 4'd0, r, d);
      tests_run++; if (d !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL rst_cmp_lo got %h want ffffffff", d); end
      bus(16'h4004, 32'd0, 4'd0, r, d);
      tests_run++; if (d !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL rst_cmp_hi got %h want ffffffff", d); end
      bus(16'h0000, 32'd0, 4'd0, r, d);
      tests_run++; if (d !== 32'd0 || soft_irpt !== 1'b0) begin tests_failed++; $display("FAIL rst_msip got %h %b want 0 0", d, soft_irpt); end
      bus(16'hBFF8, 32'd0, 4'd0, r, d);
      tests_run++; if (d !== m_mtime[31:0] || d > 32'd1) begin tests_failed++; $display("FAIL rst_mtime got %h want %h", d, m_mtime[31:0]); end
   endtask

   initial begin
      @(negedge clock);
      test_reset();
      test_timer();
      test_msip();
      test_carry();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

endmodule

// File: doc/clint_rtc.md
Name: clint_rtc

Overview:
- Memory-mapped core-local interruptor (CLINT) responder at the clint window 0x0200_0000–0x0200_BFFF.
- Answers load/store requests from the core's data bus.
- Keeps a 64-bit mtime advanced by an RTC tick derived from the system clock.
- Drives the machine timer and software interrupt lines back to the core.

Parameters:
- BASE_ADDR, 32'h0200_0000, base of the clint window; offsets are mem_addr - BASE_ADDR, low 16 bits decoded.
- RTC_DIV, 4, divider terminal count; mtime advances every 2*(RTC_DIV+1) clocks (1 GHz / 10 = 100 MHz).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- mem_valid  in  1  request strobe, one cycle per request
- mem_instr  in  1  instruction fetch flag; ignored, treated as a read
- mem_addr  in  32  byte address, word-aligned
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte write enables; 0000 = read
- mem_rdata  out  32  read data, valid when mem_ready=1
- mem_ready  out  1  response strobe
- timer_irpt  out  1  machine timer interrupt (MTIP)
- soft_irpt  out  1  machine software interrupt (MSIP)

Behaviour:
- Reset values: mem_ready=0, mem_rdata=0, msip=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, divider count=0, phase=0, timer_irpt=0, soft_irpt=0.
- Register map (offsets):
  - 0x0000: msip; bit0 only, bits 31:1 read 0.
  - 0x4000 / 0x4004: mtimecmp low / high.
  - 0xBFF8 / 0xBFFC: mtime low / high.
- Unmapped offsets: read 0; writes dropped; still answered.
- Handshake:
  - A request is accepted whenever mem_valid=1; no backpressure.
  - mem_ready=1 exactly one cycle after acceptance, for one cycle.
  - mem_rdata is registered and equals the register value sampled in the request cycle (pre-write value on a write cycle).
  - mem_rdata returns to 0 when mem_ready=0.
  - Back-to-back requests on consecutive cycles give consecutive ready pulses.
- Writes: byte-granular per mem_wstrb, committed at the clock edge ending the request cycle.
- RTC divider:
  - cnt counts 0..RTC_DIV; at RTC_DIV it wraps to 0 and phase toggles.
  - tick = (cnt==RTC_DIV && phase==1), i.e. one tick per 2*(RTC_DIV+1) clocks.
  - On tick, mtime <= mtime+1, 64-bit, wrapping from all-ones to 0.
- Simultaneous write to mtime and tick: the written bytes win; unwritten bytes of the addressed word take the incremented value. The other word is also incremented, including carry.
- timer_irpt: registered, = (mtime >= mtimecmp), unsigned 64-bit, evaluated on the post-update values, so it follows a change with one cycle delay.
- Writing mtimecmp above mtime clears timer_irpt one cycle after the write commits.
- soft_irpt = msip bit0, registered.
- Reset asserted mid-transaction: any pending mem_ready is dropped immediately (asynchronous); no response is issued after reset release.

Decomposition:
- Shared package configure (exists): clint_base_addr, clint_top_addr, clk_divider_rtc feed the BASE_ADDR / RTC_DIV defaults.
- New package constants: offsets MSIP_OFF=16'h0000, MTIMECMP_OFF=16'h4000, MTIME_OFF=16'hBFF8.
- One sub-module, rtc_divider: owns cnt/phase and outputs a single-cycle tick.
- Register file and bus decode stay in clint_rtc.

Test Plan:
- Reset release, idle 100 clocks -> mtime reads 10 (0xBFF8 → 0x0000000A), timer_irpt=0, soft_irpt=0.
- Write 0x4000=0x14, 0x4004=0 -> timer_irpt rises once mtime reaches 20, i.e. tick 20 plus one cycle; write 0x4000=0xFFFF_FFFF -> timer_irpt drops the cycle after ready.
- Write 0x0000 data 0xFFFF_FFFF strobe 1111 -> soft_irpt=1, read 0x0000 returns 0x0000_0001; write 0 -> soft_irpt=0.
- Write mtime low=0xFFFF_FFFF, high=0 -> after next tick, reads show low=0, high=1 (carry); byte write strobe 0001 data 0xAB on 0xBFF8 during a tick cycle -> byte0=0xAB, other bytes incremented.
- Back-to-back read 0xBFF8, read 0x1234 (unmapped), write 0x1234 -> three consecutive ready pulses; second read returns 0, write has no effect.
- Assert reset the cycle after a request -> mem_ready stays 0; all registers return to their reset values, mtimecmp reads all ones.
